eth_tx_framer: RTL and testbench
================================

Name: eth_tx_framer

Overview:
- Ethernet transmit framer. Sits directly upstream of crc32 and downstream of the USB-side payload FIFO.
- Pulls payload bytes over a valid/ready stream and emits one byte per clock: 7x 0x55 preamble, 0xD5 SFD, payload, zero pad, then 4-byte FCS.
- Drives crc32's enable and data inputs, and returns the finished FCS from crc32's crc_out.
- Enforces the inter-frame gap and aborts on FIFO underrun or oversize frames.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD.
- MIN_PAYLOAD, 60, minimum bytes before FCS; shorter frames are zero-padded.
- MAX_PAYLOAD, 1514, maximum bytes before FCS; beyond this the frame is truncated.
- IFG_CYCLES, 12, idle cycles after every frame.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- pl_data  in  8  payload byte from FIFO
- pl_valid  in  1  pl_data valid
- pl_last  in  1  pl_data is final payload byte
- pl_ready  out  1  framer accepts pl_data this cycle
- crc_out  in  32  crc32 running register
- crc_init  out  1  one-cycle pulse; integrator ORs it into crc32 reset to reload 0xFFFFFFFF
- crc_en  out  1  crc32 enable
- crc_data  out  8  crc32 data_in
- tx_data  out  8  transmitted byte
- tx_valid  out  1  tx_data valid
- tx_sof  out  1  high with first preamble byte
- tx_eof  out  1  high with last FCS byte
- tx_err  out  1  one-cycle pulse on abort (underrun or oversize)

Behaviour:
- Reset: state IDLE; all counters 0; pl_ready, crc_init, crc_en, tx_valid, tx_sof, tx_eof, tx_err = 0; tx_data, crc_data = 0x00.
- States: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, DROP, IFG.
- Outputs are decoded combinationally from state, counters and pl_* (zero latency).
- crc_data = tx_data in every state. crc_en = 1 only in PAYLOAD and PAD while a byte is emitted.
- IDLE:
  - Wait for pl_valid=1, without consuming the byte.
  - Next cycle: PREAMBLE, with crc_init=1 in that first PREAMBLE cycle.
- PREAMBLE:
  - Emit 0x55 for PREAMBLE_LEN cycles; tx_sof=1 on the first.
  - Then SFD: emit 0xD5 for one cycle.
- PAYLOAD:
  - pl_ready=1. If pl_valid, tx_data=pl_data, tx_valid=1, byte count increments (11 bits).
  - If pl_valid=0: underrun. tx_err=1, tx_valid=0, go to IFG; no FCS is sent.
  - pl_last with count+1 < MIN_PAYLOAD: go to PAD.
  - pl_last otherwise: go to FCS.
  - count+1 == MAX_PAYLOAD without pl_last: tx_err=1, go to DROP. The frame completes normally through FCS after DROP.
- PAD: emit 0x00 until count == MIN_PAYLOAD, then FCS.
- DROP:
  - pl_ready=1, tx_valid=0; consume and discard bytes until pl_valid & pl_last, then FCS.
  - Any pl_valid gaps here are tolerated.
- FCS:
  - 4 cycles, k=0..3.
  - k=0: tx_data=~crc_out[7:0]; latch crc_out into fcs_q.
  - k=1..3: tx_data=~fcs_q[8k+7:8k].
  - tx_eof=1 on k=3. Then IFG.
- IFG: IFG_CYCLES cycles, tx_valid=0, pl_ready=0, then IDLE. A new frame cannot start earlier.
- pl_ready=0 in every state except PAYLOAD and DROP.
- tx_valid=1 in PREAMBLE, SFD, PAYLOAD (when a byte is accepted), PAD and FCS.
- n_rst mid-frame: immediately return to the reset values. A partially sent frame is abandoned with no tx_eof; the next frame starts with a fresh crc_init.

Optional Feature:
- Macro ETH_TX_PAD_EN.
- Defined: PAD state and MIN_PAYLOAD enforcement as above.
- Undefined: PAD state is removed; pl_last always goes to FCS regardless of length; MIN_PAYLOAD is ignored.

Test Plan:
- n_rst low mid-FCS -> all outputs 0 next sample; next frame begins with tx_sof and crc_init=1.
- ETH_TX_PAD_EN undefined, payload 0x31..0x39 ("123456789") with crc32 instantiated -> tx stream is 55x7, D5, 31..39, then 26 39 F4 CB; tx_eof on 0xCB; 12 idle cycles follow.
- ETH_TX_PAD_EN defined, 3-byte payload AB CD EF -> 57 zero pad bytes (60 total); crc_en high for exactly 60 cycles; FCS equals ~crc_out captured after the 60th byte.
- pl_valid dropped after 10 payload bytes -> tx_err pulse that cycle; no FCS, no tx_eof; IFG 12 cycles; next pl_valid starts a clean frame.
- 1600-byte payload -> 1514 bytes emitted, tx_err at byte 1514, remaining 86 bytes consumed with tx_valid=0, then 4 FCS bytes and tx_eof.
- Two back-to-back frames with pl_valid held high -> exactly 12 cycles of tx_valid=0 between tx_eof and the next tx_sof.

Source files
------------

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble, SFD, payload, optional zero pad and FCS, with inter-frame gap and abort.
// Define ETH_TX_PAD_EN to pad short frames up to MIN_PAYLOAD bytes before the FCS.
module eth_tx_framer #(
`ifdef ETH_TX_PAD_EN
    parameter int MIN_PAYLOAD  = 60,
`endif
    parameter int PREAMBLE_LEN = 7,
    parameter int MAX_PAYLOAD  = 1514,
    parameter int IFG_CYCLES   = 12
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    input  logic        pl_last,
    output logic        pl_ready,
    input  logic [31:0] crc_out,
    output logic        crc_init,
    output logic        crc_en,
    output logic [7:0]  crc_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        tx_err
);

    // state    | meaning
    // IDLE     | waiting for the first payload byte to be offered
    // PREAMBLE | sending 0x55 bytes, crc reload on the first
    // SFD      | sending 0xD5
    // PAYLOAD  | forwarding payload bytes into tx and crc
    // PAD      | sending zero bytes up to the minimum length
    // FCS      | sending the inverted crc, low byte first
    // DROP     | oversize: discarding the rest of the payload
    // IFG      | enforced idle gap between frames
    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
`ifdef ETH_TX_PAD_EN
        PAD,
`endif
        FCS,
        DROP,
        IFG
    } state_t;

    localparam int CNT_MAX = (PREAMBLE_LEN > IFG_CYCLES) ? PREAMBLE_LEN : IFG_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(3);
    localparam logic [10:0]      MAX_W    = 11'(MAX_PAYLOAD);
`ifdef ETH_TX_PAD_EN
    localparam logic [10:0]      MIN_W    = 11'(MIN_PAYLOAD);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]      fcs_q, fcs_d;
    logic [10:0]      byte_cnt_inc;

    assign byte_cnt_inc = byte_cnt_q + 11'd1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            fcs_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            fcs_q      <= fcs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        fcs_d      = fcs_q;
        case (state_q)
            IDLE: begin
                if (pl_valid) begin
                    state_d = PREAMBLE;
                    cnt_d   = '0;
                end
            end
            PREAMBLE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SFD: begin
                state_d    = PAYLOAD;
                byte_cnt_d = '0;
            end
            PAYLOAD: begin
                if (!pl_valid) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end else begin
                    byte_cnt_d = byte_cnt_inc;
                    if (pl_last) begin
                        state_d = FCS;
                        cnt_d   = '0;
`ifdef ETH_TX_PAD_EN
                        if (byte_cnt_inc < MIN_W) state_d = PAD;
`endif
                    end else if (byte_cnt_inc == MAX_W) begin
                        state_d = DROP;
                    end
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                byte_cnt_d = byte_cnt_inc;
                if (byte_cnt_inc == MIN_W) begin
                    state_d = FCS;
                    cnt_d   = '0;
                end
            end
`endif
            DROP: begin
                if (pl_valid && pl_last) begin
                    state_d = FCS;
                    cnt_d   = '0;
                end
            end
            FCS: begin
                // Low byte goes out straight from crc_out; the rest is frozen here.
                if (cnt_q == '0) fcs_d = crc_out[31:8];
                if (cnt_q == FCS_LAST) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IFG: begin
                // A waiting frame starts right after the gap, so the gap is exactly IFG_CYCLES.
                if (cnt_q == IFG_LAST) begin
                    state_d = pl_valid ? PREAMBLE : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pl_ready = 1'b0;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_sof   = 1'b0;
        tx_eof   = 1'b0;
        tx_err   = 1'b0;
        case (state_q)
            PREAMBLE: begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                tx_sof   = (cnt_q == '0);
                crc_init = (cnt_q == '0);
            end
            SFD: begin
                tx_data  = 8'hD5;
                tx_valid = 1'b1;
            end
            PAYLOAD: begin
                pl_ready = 1'b1;
                if (pl_valid) begin
                    tx_data  = pl_data;
                    tx_valid = 1'b1;
                    crc_en   = 1'b1;
                    tx_err   = !pl_last && (byte_cnt_inc == MAX_W);
                end else begin
                    tx_err = 1'b1;
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                tx_valid = 1'b1;
                crc_en   = 1'b1;
            end
`endif
            DROP: begin
                pl_ready = 1'b1;
            end
            FCS: begin
                tx_valid = 1'b1;
                tx_eof   = (cnt_q == FCS_LAST);
                case (cnt_q[1:0])
                    2'd0:    tx_data = ~crc_out[7:0];
                    2'd1:    tx_data = ~fcs_q[7:0];
                    2'd2:    tx_data = ~fcs_q[15:8];
                    default: tx_data = ~fcs_q[23:16];
                endcase
            end
            default: begin
            end
        endcase
    end

    assign crc_data = tx_data;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer with a behavioural reflected CRC-32 standing in for crc32.
module tb_eth_tx_framer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_last;
    logic        pl_ready;
    logic [31:0] crc_out;
    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_sof;
    logic        tx_eof;
    logic        tx_err;

    eth_tx_framer dut (
        .clk(clk), .n_rst(n_rst),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last), .pl_ready(pl_ready),
        .crc_out(crc_out), .crc_init(crc_init), .crc_en(crc_en), .crc_data(crc_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic [31:0] crc_reg;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)        crc_reg <= 32'hFFFFFFFF;
        else if (crc_init) crc_reg <= 32'hFFFFFFFF;
        else if (crc_en)   crc_reg <= crc_upd(crc_reg, crc_data);
    end
    assign crc_out = crc_reg;

    logic [22:0] outs;
    assign outs = {pl_ready, crc_init, crc_en, crc_data, tx_data, tx_valid, tx_sof, tx_eof, tx_err};

    typedef struct {
        logic        v;
        logic        l;
        logic [7:0]  d;
        logic [22:0] e;
    } vec_t;
    vec_t vecs[$];

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int cd_bad = 0;

    logic [7:0] pl_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    int idx, sof_n, eof_n, err_n, en_n, init_n, init_sof_n, pre_valid, err_pos, sof_cyc, eof_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] pk(logic r, logic i, logic e, logic [7:0] d,
                                       logic v, logic s, logic eo, logic er);
        return {r, i, e, d, d, v, s, eo, er};
    endfunction

    task automatic add(input logic v, input logic l, input logic [7:0] d, input logic [22:0] e);
        vec_t r;
        r.v = v; r.l = l; r.d = d; r.e = e;
        vecs.push_back(r);
    endtask

    // Expected wire stream for the first n bytes of pl_q, padded and closed with FCS when requested.
    task automatic build_exp(input int n, input bit with_fcs);
        logic [31:0] c;
        int plen;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pl_q[i]);
            c = crc_upd(c, pl_q[i]);
        end
        if (with_fcs) begin
            plen = n;
`ifdef ETH_TX_PAD_EN
            while (plen < 60) begin
                exp_q.push_back(8'h00);
                c = crc_upd(c, 8'h00);
                plen++;
            end
`endif
            c = ~c;
            for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
        end
    endtask

    task automatic cmp_stream(input string name);
        int mism;
        int n;
        mism = 0;
        n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (tx_q[i] !== exp_q[i]) mism++;
        chk({name, "_len"}, tx_q.size(), exp_q.size());
        chk({name, "_bytes_wrong"}, mism, 0);
    endtask

    task automatic send_frame(input int drop_after, input bit hold, input int stop_len, input int budget);
        int n;
        bit done;
        n = 0; done = 0; idx = 0;
        tx_q.delete();
        sof_n = 0; eof_n = 0; err_n = 0; en_n = 0; init_n = 0; init_sof_n = 0;
        pre_valid = 0; err_pos = -1; sof_cyc = -1; eof_cyc = -1;
        while (!done && n < budget) begin
            if (drop_after >= 0 && idx >= drop_after) begin
                pl_valid = 1'b0; pl_data = 8'h00; pl_last = 1'b0;
            end else if (idx < pl_q.size()) begin
                pl_valid = 1'b1; pl_data = pl_q[idx]; pl_last = (idx == pl_q.size() - 1);
            end else begin
                pl_valid = hold; pl_data = 8'h00; pl_last = 1'b0;
            end
            @(negedge clk);
            if (pl_valid && pl_ready) idx++;
            if (tx_valid) tx_q.push_back(tx_data);
            if (sof_n == 0 && tx_valid && !tx_sof) pre_valid++;
            if (tx_sof) begin
                sof_n++;
                if (sof_cyc < 0) sof_cyc = cyc_n;
            end
            if (crc_init) begin
                init_n++;
                if (tx_sof) init_sof_n++;
            end
            if (crc_en) en_n++;
            if (crc_data !== tx_data) cd_bad++;
            if (tx_err) begin
                err_n++;
                err_pos = tx_q.size();
                if (!tx_valid) done = 1;
            end
            if (tx_eof) begin
                eof_n++;
                eof_cyc = cyc_n;
                done = 1;
            end
            if (stop_len > 0 && tx_q.size() >= stop_len) done = 1;
            cyc_n++;
            n++;
            @(posedge clk);
            #1;
        end
        chk("frame_done", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q_bad;
        int eof_a;
        int start;

        n_rst = 1'b0; pl_valid = 1'b0; pl_last = 1'b0; pl_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        pl_valid = 1'b1;
        #1;
        chk("reset_outs", outs, 0);
        pl_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Cycle-exact table for payload "123456789".
        pl_q.delete();
        for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
        build_exp(9, 1);
        add(1'b1, 1'b0, 8'h31, 23'd0);
        for (int i = 0; i < 7; i++)
            add(1'b1, 1'b0, 8'h31, pk(0, i == 0, 0, 8'h55, 1, i == 0, 0, 0));
        add(1'b1, 1'b0, 8'h31, pk(0, 0, 0, 8'hD5, 1, 0, 0, 0));
        for (int k = 0; k < 9; k++)
            add(1'b1, k == 8, 8'h31 + 8'(k), pk(1, 0, 1, 8'h31 + 8'(k), 1, 0, 0, 0));
`ifdef ETH_TX_PAD_EN
        for (int k = 0; k < 51; k++)
            add(1'b0, 1'b0, 8'h00, pk(0, 0, 1, 8'h00, 1, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            add(1'b0, 1'b0, 8'h00, pk(0, 0, 0, exp_q[68 + k], 1, 0, k == 3, 0));
`else
        add(1'b0, 1'b0, 8'h00, pk(0, 0, 0, 8'h26, 1, 0, 0, 0));
        add(1'b0, 1'b0, 8'h00, pk(0, 0, 0, 8'h39, 1, 0, 0, 0));
        add(1'b0, 1'b0, 8'h00, pk(0, 0, 0, 8'hF4, 1, 0, 0, 0));
        add(1'b0, 1'b0, 8'h00, pk(0, 0, 0, 8'hCB, 1, 0, 1, 0));
`endif
        for (int k = 0; k < 13; k++) add(1'b0, 1'b0, 8'h00, 23'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            pl_valid = vecs[i].v; pl_last = vecs[i].l; pl_data = vecs[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs, vecs[i].e);
            cyc_n++;
            @(posedge clk);
            #1;
        end

        // Short frame: padded to 60 bytes when padding is built in.
        pl_q = '{8'hAB, 8'hCD, 8'hEF};
        build_exp(3, 1);
        send_frame(-1, 1'b0, 0, 300);
        cmp_stream("short");
        chk("short_crc_en_cycles", en_n, exp_q.size() - 12);
        chk("short_eof", eof_n, 1);
        chk("short_err", err_n, 0);

        // Underrun after 10 bytes, then the gap with the next frame already waiting.
        pl_q.delete();
        for (int i = 0; i < 20; i++) pl_q.push_back(8'h80 + 8'(i));
        build_exp(10, 0);
        send_frame(10, 1'b0, 0, 300);
        cmp_stream("underrun");
        chk("underrun_err", err_n, 1);
        chk("underrun_err_pos", err_pos, 18);
        chk("underrun_no_eof", eof_n, 0);
        pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        q_bad = 0;
        for (int i = 0; i < 12; i++) begin
            pl_valid = 1'b1; pl_data = 8'h11; pl_last = 1'b0;
            @(negedge clk);
            if (tx_valid || tx_sof || tx_eof || tx_err || pl_ready || crc_en || crc_init) q_bad++;
            cyc_n++;
            @(posedge clk);
            #1;
        end
        chk("underrun_ifg_quiet", q_bad, 0);
        build_exp(4, 1);
        start = cyc_n;
        send_frame(-1, 1'b0, 0, 300);
        chk("after_underrun_sof_cycle", sof_cyc - start, 0);
        chk("after_underrun_init", init_sof_n, 1);
        cmp_stream("after_underrun");

        // Oversize: 1600 offered, 1514 sent, rest dropped.
        pl_q.delete();
        for (int i = 0; i < 1600; i++) pl_q.push_back(8'(i * 7 + 3));
        build_exp(1514, 1);
        send_frame(-1, 1'b0, 0, 2000);
        cmp_stream("oversize");
        chk("oversize_err", err_n, 1);
        chk("oversize_err_pos", err_pos, 8 + 1514);
        chk("oversize_consumed", idx, 1600);
        chk("oversize_crc_en_cycles", en_n, 1514);
        chk("oversize_eof", eof_n, 1);

        // Back-to-back frames with pl_valid held high.
        pl_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        build_exp(5, 1);
        send_frame(-1, 1'b1, 0, 300);
        cmp_stream("b2b_a");
        eof_a = eof_cyc;
        pl_q = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4};
        build_exp(5, 1);
        send_frame(-1, 1'b0, 0, 300);
        cmp_stream("b2b_b");
        chk("b2b_gap", sof_cyc - eof_a - 1, 12);
        chk("b2b_gap_quiet", pre_valid, 0);

        // Reset while the FCS is going out.
        pl_q = '{8'h77};
        build_exp(1, 1);
        send_frame(-1, 1'b0, exp_q.size() - 3, 300);
        n_rst = 1'b0;
        #2;
        chk("midfcs_reset_outs", outs, 0);
        chk("midfcs_no_eof", eof_n, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        pl_q = '{8'h5A, 8'hA5};
        build_exp(2, 1);
        start = cyc_n;
        send_frame(-1, 1'b0, 0, 300);
        chk("post_reset_sof_cycle", sof_cyc - start, 1);
        chk("post_reset_init_with_sof", init_sof_n, 1);
        chk("post_reset_init_count", init_n, 1);
        cmp_stream("post_reset");

        chk("crc_data_tracks_tx", cd_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
